// File: rtl/sk9822_pkg.sv
// Shared definitions for the SK9822 serial link: receiver FSM states,
// word geometry and the pixel-word field layout. The strip driver uses
// the same package so both ends agree on the framing.
package sk9822_pkg;

    localparam int WORD_W      = 32;
    localparam int START_ZEROS = 32;

    // Field positions inside a pixel word
    localparam int HDR_MSB = 31;
    localparam int HDR_LSB = 29;
    localparam int BRT_MSB = 28;
    localparam int BRT_LSB = 24;
    localparam int COL_MSB = 23;
    localparam int COL_LSB = 0;

    localparam logic [2:0] PIXEL_HEADER = 3'b111;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        PIXEL = 2'd1,
        TAIL  = 2'd2
    } rx_state_t;

    // A word is a pixel only when its three top bits are all ones
    function automatic logic header_ok(input logic [WORD_W-1:0] w);
        return w[HDR_MSB:HDR_LSB] == PIXEL_HEADER;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous SK9822 clock and data into the clk domain and
// flags each rising serial-clock edge. Data goes through the same two
// flops as the clock so the sampled bit lines up with the detected edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sk9822_clk,
    input  logic sk9822_data,
    output logic bit_strobe,
    output logic bit_value
);

    logic clk_p0, clk_p1, clk_p2;
    logic data_p0, data_p1;

    // Two-flop synchronisers plus one history flop on the clock for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_p0  <= 1'b0;
            clk_p1  <= 1'b0;
            clk_p2  <= 1'b0;
            data_p0 <= 1'b0;
            data_p1 <= 1'b0;
        end else begin
            clk_p0  <= sk9822_clk;
            clk_p1  <= clk_p0;
            clk_p2  <= clk_p1;
            data_p0 <= sk9822_data;
            data_p1 <= data_p0;
        end
    end

    assign bit_strobe = clk_p1 & ~clk_p2;
    assign bit_value  = data_p1;

endmodule

// File: rtl/sk9822_frame_receiver.sv
// Receives an SK9822 frame stream: hunts for the 32-zero start frame,
// collects n_leds pixel words into a staging buffer and publishes the
// whole frame on data_rgb only once the last pixel has arrived. Bad
// headers and mid-frame stalls abort the frame and resynchronise.
module sk9822_frame_receiver
    import sk9822_pkg::*;
#(
    parameter int n_leds         = 13,
    parameter int timeout_cycles = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sk9822_clk,
    input  logic                       sk9822_data,
    output logic                       pixel_valid,
    output logic [$clog2(n_leds)-1:0]  pixel_idx,
    output logic [31:0]                pixel_word,
    output logic                       frame_done,
    output logic                       frame_error,
    output logic [0:n_leds-1][31:0]    data_rgb
);

    localparam int IDX_W  = $clog2(n_leds);
    localparam int IDLE_W = $clog2(timeout_cycles + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(n_leds - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(timeout_cycles - 1);
    localparam logic [4:0]        LAST_BIT   = 5'(WORD_W - 1);
    localparam logic [4:0]        LAST_ZERO  = 5'(START_ZEROS - 1);

    rx_state_t                  state;
    logic [4:0]                 bit_cnt;
    logic [4:0]                 zero_cnt;
    logic [IDX_W-1:0]           pix_cnt;
    logic [IDLE_W-1:0]          idle_cnt;
    logic [WORD_W-2:0]          shreg;
    logic [0:n_leds-1][31:0]    staging;

    logic                       bit_strobe;
    logic                       bit_value;
    logic                       timeout_fire;
    logic                       take_bit;
    logic                       skip_zero;
    logic                       shift_en;
    logic                       stage_wr;
    logic [WORD_W-1:0]          word_next;

    sync_edge_detect u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .sk9822_clk  (sk9822_clk),
        .sk9822_data (sk9822_data),
        .bit_strobe  (bit_strobe),
        .bit_value   (bit_value)
    );

    // A timeout coinciding with an edge wins and the bit is dropped.
    // Leading zeros of an over-long start frame are swallowed until the
    // first header bit of pixel 0.
    always_comb begin
        timeout_fire = (idle_cnt == IDLE_LIMIT);
        take_bit     = bit_strobe & ~timeout_fire;
        skip_zero    = (pix_cnt == '0) && (bit_cnt == '0) && !bit_value;
        shift_en     = take_bit && (state == PIXEL) && !skip_zero;
        word_next    = {shreg, bit_value};
        stage_wr     = shift_en && (bit_cnt == LAST_BIT) && header_ok(word_next);
    end

    // Shift register and staging buffer carry data only, so they are not reset
    always_ff @(posedge clk) begin
        if (shift_en)
            shreg <= word_next[WORD_W-2:0];
        if (stage_wr)
            staging[pix_cnt] <= word_next;
    end

    // Framing FSM, idle watchdog and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            bit_cnt     <= '0;
            zero_cnt    <= '0;
            pix_cnt     <= '0;
            idle_cnt    <= '0;
            pixel_valid <= 1'b0;
            pixel_idx   <= '0;
            pixel_word  <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            data_rgb    <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;

            if (timeout_fire) begin
                if (state == PIXEL && (bit_cnt != '0 || pix_cnt != '0))
                    frame_error <= 1'b1;
                state    <= HUNT;
                bit_cnt  <= '0;
                pix_cnt  <= '0;
                zero_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= bit_strobe ? '0 : idle_cnt + 1'b1;

                if (bit_strobe) begin
                    case (state)
                        HUNT, TAIL: begin
                            if (bit_value) begin
                                zero_cnt <= '0;
                            end else if (zero_cnt == LAST_ZERO) begin
                                zero_cnt <= '0;
                                bit_cnt  <= '0;
                                pix_cnt  <= '0;
                                state    <= PIXEL;
                            end else begin
                                zero_cnt <= zero_cnt + 1'b1;
                            end
                        end
                        PIXEL: begin
                            if (!skip_zero) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == LAST_BIT) begin
                                    if (header_ok(word_next)) begin
                                        pixel_valid <= 1'b1;
                                        pixel_idx   <= pix_cnt;
                                        pixel_word  <= word_next;
                                        if (pix_cnt == LAST_IDX) begin
                                            frame_done <= 1'b1;
                                            data_rgb   <= staging;
                                            data_rgb[n_leds-1] <= word_next;
                                            pix_cnt    <= '0;
                                            zero_cnt   <= '0;
                                            state      <= TAIL;
                                        end else begin
                                            pix_cnt <= pix_cnt + 1'b1;
                                        end
                                    end else begin
                                        frame_error <= 1'b1;
                                        pix_cnt     <= '0;
                                        zero_cnt    <= '0;
                                        state       <= HUNT;
                                    end
                                end
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/sk9822_frame_receiver.md
SK9822_FRAME_RECEIVER -- requirements
Module: sk9822_frame_receiver

Interface
REQ-001 Parameter n_leds, default 13: pixel words per frame.
REQ-002 Parameter timeout_cycles, default 1024: clk cycles of idle sk9822_clk after which the receiver resynchronises.
REQ-003 Port clk  input  1: single system clock; all logic in this domain.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port sk9822_clk  input  1: serial clock from the strip driver, asynchronous to clk.
REQ-006 Port sk9822_data  input  1: serial data, MSB first, valid on sk9822_clk rising edge.
REQ-007 Port pixel_valid  output  1: one-cycle pulse, one pixel word received.
REQ-008 Port pixel_idx  output  $clog2(n_leds): position of the pixel in the frame, 0 = first after the start frame.
REQ-009 Port pixel_word  output  32: raw word: [31:29] header, [28:24] brightness, [23:0] colour bytes in wire order.
REQ-010 Port frame_done  output  1: one-cycle pulse, n_leds valid pixels received.
REQ-011 Port frame_error  output  1: one-cycle pulse, bad header or timeout mid-frame.
REQ-012 Port data_rgb  output  [0:n_leds-1][31:0]: last complete frame, same layout as the strip driver input.

Function
REQ-013 Both serial inputs SHALL pass through a 2-flop synchroniser; the rising edge of sk9822_clk SHALL be detected on the synchronised copy, and data SHALL be sampled in the same cycle from the equally delayed data copy.
REQ-014 Bits SHALL shift into a 32-bit register MSB first; a 5-bit counter SHALL count bits within the current word.
REQ-015 The FSM SHALL have states HUNT, PIXEL and TAIL.
REQ-016 HUNT: count consecutive zero bits; any one-bit clears the count; at 32 zeros -> PIXEL with bit count 0 and pixel index 0.
REQ-017 PIXEL: extra zero bits before the first header bit SHALL be ignored (start frame longer than 32 bits); the word begins at the first one-bit.
REQ-018 PIXEL, word complete with [31:29] = 3'b111: pixel_valid, pixel_idx and pixel_word SHALL be asserted in the cycle after the 32nd edge is detected; the word SHALL be stored in the staging buffer at pixel_idx.
REQ-019 PIXEL, word complete with [31:29] != 3'b111: frame_error SHALL pulse, no pixel_valid, -> HUNT.
REQ-020 When pixel index n_leds-1 is accepted, frame_done SHALL pulse in the same cycle as that pixel_valid; data_rgb SHALL copy the whole staging buffer atomically on that cycle; -> TAIL.
REQ-021 TAIL: end-frame bits SHALL be discarded; 32 consecutive zero bits SHALL start a new frame exactly as in HUNT (-> PIXEL).
REQ-022 An idle counter SHALL reset on every detected edge; on reaching timeout_cycles, bit and pixel counters SHALL clear and the FSM SHALL go to HUNT; frame_error SHALL pulse only if the state was PIXEL with at least one bit or pixel received.
REQ-023 data_rgb SHALL never show a partially received frame; an aborted frame leaves it unchanged.
REQ-024 The pixel index SHALL not wrap: the state goes to TAIL at n_leds-1.
REQ-025 If an edge is detected in the same cycle the timeout fires, the timeout SHALL win and the bit SHALL be discarded.

Reset
REQ-026 On rst_n low: state HUNT, all counters 0, synchronisers 0, pixel_valid/frame_done/frame_error 0, pixel_idx 0, pixel_word 0, data_rgb all zero.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a frame_done or frame_error pulse.

Structure
REQ-028 Package sk9822_pkg SHALL hold the state enum, the header constant 3'b111, word width 32 and the field bit positions; the strip driver SHALL use the same package.
REQ-029 The synchroniser plus edge detector SHALL be one sub-module, sync_edge_detect; all other logic stays in this module.

Verification
REQ-030 Loopback with led_strip_combo (n_leds 13): data_rgb[0] = {3'd7,5'd15,24'h110000} -> frame_done every frame and data_rgb equal to the driver input.
REQ-031 Direct bit stream: 32 zeros, then 13 words 0xFF000000+i (i = 0..12) -> 13 pixel_valid with pixel_idx 0..12, frame_done on idx 12.
REQ-032 Word 5 sent as 0x5F123456 (header 010) -> frame_error, pixels 0..4 only, data_rgb unchanged from the prior frame.
REQ-033 Stop after 7 pixels, idle 1100 cycles -> frame_error once, state HUNT; the next full frame is received correctly.
REQ-034 40-zero start frame followed by pixels -> alignment correct; pixel_word[0] = 0xE7AABBCC.
REQ-035 rst_n low during pixel 3 -> all outputs zero immediately, no pulses; a full frame after release is received.
